// File: rtl/ffsr_binary_spike_tx.sv
// Spike-train transmitter for the flip-flop shift-register counter link.
// Converts a binary target into active-low inc/dec spikes. A local shadow of the
// remote count decides the direction and spike count, so there is no feedback path.
module ffsr_binary_spike_tx #(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned SPIKE_LOW = 1,
   parameter int unsigned GAP       = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_target,
   output logic             o_inc,
   output logic             o_dec,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_shadow
);

   // Phase timer is WIDTH+1 bits, but never narrower than 4 so any legal phase length fits
   localparam int unsigned TW = (WIDTH + 1 > 4) ? (WIDTH + 1) : 4;
   localparam logic [TW-1:0] LOW_LOAD  = TW'(SPIKE_LOW - 1);
   localparam logic [TW-1:0] HIGH_LOAD = TW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_tgt;
   logic [WIDTH-1:0] r_shadow;
   logic [TW-1:0]    r_timer;
   logic             r_up;
   logic             r_inc;
   logic             r_dec;
   logic             r_busy;
   logic             r_done;

   logic             w_tgt_eq;
   logic             w_tgt_up;
   logic [WIDTH-1:0] w_shadow_p1;
   logic [WIDTH-1:0] w_shadow_m1;

   // Request decode against the current shadow, plus the two neighbouring counts
   always_comb begin
      w_tgt_eq    = (i_target == r_shadow);
      w_tgt_up    = (i_target > r_shadow);
      w_shadow_p1 = r_shadow + WIDTH'(1);
      w_shadow_m1 = r_shadow - WIDTH'(1);
   end

   // Spike sequencer: shadow moves on the same edge that drops the spike line
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_tgt    <= '0;
         r_shadow <= '0;
         r_timer  <= '0;
         r_up     <= 1'b0;
         r_inc    <= 1'b1;
         r_dec    <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_inc   <= 1'b1;
               r_dec   <= 1'b1;
               if (i_load) begin
                  r_tgt <= i_target;
                  if (w_tgt_eq) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_LOW;
                     r_busy  <= 1'b1;
                     r_up    <= w_tgt_up;
                     r_timer <= LOW_LOAD;
                     if (w_tgt_up) begin
                        r_inc    <= 1'b0;
                        r_shadow <= w_shadow_p1;
                     end else begin
                        r_dec    <= 1'b0;
                        r_shadow <= w_shadow_m1;
                     end
                  end
               end
            end
            S_LOW: begin
               if (r_timer == '0) begin
                  r_state <= S_HIGH;
                  r_inc   <= 1'b1;
                  r_dec   <= 1'b1;
                  r_timer <= HIGH_LOAD;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_HIGH: begin
               if (r_timer != '0) begin
                  r_timer <= r_timer - TW'(1);
               end else if (r_shadow == r_tgt) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_LOW;
                  r_timer <= LOW_LOAD;
                  if (r_up) begin
                     r_inc    <= 1'b0;
                     r_shadow <= w_shadow_p1;
                  end else begin
                     r_dec    <= 1'b0;
                     r_shadow <= w_shadow_m1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_inc   <= 1'b1;
               r_dec   <= 1'b1;
            end
         endcase
      end
   end

   // Registered outputs straight from state flops
   always_comb begin
      o_inc    = r_inc;
      o_dec    = r_dec;
      o_busy   = r_busy;
      o_done   = r_done;
      o_shadow = r_shadow;
   end

endmodule
